// File: rtl/fcore_isa_pkg.sv
// Shared fCore ISA definitions: opcode numbering, one-hot functional-unit classes
// and decode-stage FSM states, imported by both the decode and execute stages.
package fcore_isa;

  localparam int OPCODE_WIDTH_DEFAULT = 5;
  localparam int CLASS_WIDTH          = 7;

  localparam int unsigned OP_NOP    = 0;
  localparam int unsigned OP_ADD    = 1;
  localparam int unsigned OP_SUB    = 2;
  localparam int unsigned OP_MUL    = 3;
  localparam int unsigned OP_ITF    = 4;
  localparam int unsigned OP_FTI    = 5;
  localparam int unsigned OP_LDC    = 6;
  localparam int unsigned OP_LDR    = 7;
  localparam int unsigned OP_BGT    = 8;
  localparam int unsigned OP_BLE    = 9;
  localparam int unsigned OP_BEQ    = 10;
  localparam int unsigned OP_BNE    = 11;
  localparam int unsigned OP_STOP   = 12;
  localparam int unsigned OP_LAND   = 13;
  localparam int unsigned OP_LOR    = 14;
  localparam int unsigned OP_LNOT   = 15;
  localparam int unsigned OP_SATP   = 16;
  localparam int unsigned OP_SATN   = 17;
  localparam int unsigned OP_REC    = 18;
  localparam int unsigned OP_POPCNT = 19;
  localparam int unsigned OP_ABS    = 20;
  localparam int unsigned OP_LAST   = OP_ABS;

  typedef enum logic [CLASS_WIDTH-1:0] {
    CLASS_NOP     = 7'b0000001,
    CLASS_ARITH   = 7'b0000010,
    CLASS_CONVERT = 7'b0000100,
    CLASS_LOAD    = 7'b0001000,
    CLASS_BRANCH  = 7'b0010000,
    CLASS_LOGIC   = 7'b0100000,
    CLASS_CONTROL = 7'b1000000
  } fcore_class_e;

  typedef enum logic [1:0] {
    DEC_HALTED   = 2'd0,
    DEC_RUN      = 2'd1,
    DEC_LDC_WAIT = 2'd2
  } dec_state_e;

  function automatic logic is_opcode_legal(input logic [31:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/fcore_opcode_classifier.sv
// Purely combinational opcode-to-class mapping; shared by decode and the execute
// stage's hazard logic. Illegal opcodes report the NOP class.
module fcore_opcode_classifier
  import fcore_isa::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEFAULT
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output fcore_class_e            op_class,
  output logic                    illegal
);

  logic [31:0] op_val;

  assign op_val = 32'(opcode);

  always_comb begin
    op_class = CLASS_NOP;
    illegal  = 1'b0;
    case (op_val)
      OP_NOP:                                                op_class = CLASS_NOP;
      OP_ADD, OP_SUB, OP_MUL, OP_SATP, OP_SATN, OP_REC, OP_ABS: op_class = CLASS_ARITH;
      OP_ITF, OP_FTI:                                        op_class = CLASS_CONVERT;
      OP_LDC, OP_LDR:                                        op_class = CLASS_LOAD;
      OP_BGT, OP_BLE, OP_BEQ, OP_BNE:                        op_class = CLASS_BRANCH;
      OP_LAND, OP_LOR, OP_LNOT, OP_POPCNT:                   op_class = CLASS_LOGIC;
      OP_STOP:                                               op_class = CLASS_CONTROL;
      default:                                               op_class = CLASS_NOP;
    endcase
    if (!is_opcode_legal(op_val)) begin
      illegal  = 1'b1;
      op_class = CLASS_NOP;
    end
  end

endmodule

// File: rtl/fcore_decode_stage.sv
// fCore decode stage: splits fetch words into fields, classifies the opcode, pairs
// LDC with its constant word and halts on STOP until restarted.
module fcore_decode_stage
  import fcore_isa::*;
#(
  parameter int INSTRUCTION_WIDTH   = 32,
  parameter int OPCODE_WIDTH        = OPCODE_WIDTH_DEFAULT,
  parameter int REGISTER_ADDR_WIDTH = 4,
  parameter int CHANNEL_ADDR_WIDTH  = 2,
  localparam int CHANNEL_OUT_WIDTH  = (CHANNEL_ADDR_WIDTH > 0) ? CHANNEL_ADDR_WIDTH : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           flush,
  input  logic [INSTRUCTION_WIDTH-1:0]   in_instruction,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [OPCODE_WIDTH-1:0]        out_opcode,
  output logic [REGISTER_ADDR_WIDTH-1:0] out_op_a,
  output logic [REGISTER_ADDR_WIDTH-1:0] out_op_b,
  output logic [REGISTER_ADDR_WIDTH-1:0] out_dest,
  output logic [CHANNEL_OUT_WIDTH-1:0]   out_channel,
  output logic [INSTRUCTION_WIDTH-1:0]   out_immediate,
  output logic [CLASS_WIDTH-1:0]         out_class,
  output logic                           out_illegal,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           halted
);

  localparam int OP_A_LSB    = OPCODE_WIDTH;
  localparam int OP_B_LSB    = OP_A_LSB + REGISTER_ADDR_WIDTH;
  localparam int DEST_LSB    = OP_B_LSB + REGISTER_ADDR_WIDTH;
  localparam int CHANNEL_LSB = DEST_LSB + REGISTER_ADDR_WIDTH;

  dec_state_e state_q, state_d;

  logic [OPCODE_WIDTH-1:0]        out_opcode_q, out_opcode_d;
  logic [REGISTER_ADDR_WIDTH-1:0] out_op_a_q, out_op_a_d;
  logic [REGISTER_ADDR_WIDTH-1:0] out_op_b_q, out_op_b_d;
  logic [REGISTER_ADDR_WIDTH-1:0] out_dest_q, out_dest_d;
  logic [CHANNEL_OUT_WIDTH-1:0]   out_channel_q, out_channel_d;
  logic [INSTRUCTION_WIDTH-1:0]   out_immediate_q, out_immediate_d;
  logic [CLASS_WIDTH-1:0]         out_class_q, out_class_d;
  logic                           out_illegal_q, out_illegal_d;
  logic                           out_valid_q, out_valid_d;

  logic [REGISTER_ADDR_WIDTH-1:0] ldc_op_a_q, ldc_op_a_d;
  logic [REGISTER_ADDR_WIDTH-1:0] ldc_op_b_q, ldc_op_b_d;
  logic [REGISTER_ADDR_WIDTH-1:0] ldc_dest_q, ldc_dest_d;
  logic [CHANNEL_OUT_WIDTH-1:0]   ldc_channel_q, ldc_channel_d;

  logic [OPCODE_WIDTH-1:0]        in_opcode;
  logic [REGISTER_ADDR_WIDTH-1:0] in_op_a;
  logic [REGISTER_ADDR_WIDTH-1:0] in_op_b;
  logic [REGISTER_ADDR_WIDTH-1:0] in_dest;
  logic [CHANNEL_OUT_WIDTH-1:0]   in_channel;
  fcore_class_e                   in_class;
  logic                           in_illegal;
  logic                           in_is_ldc;
  logic                           in_is_stop;
  logic                           is_halted;
  logic                           flush_eff;
  logic                           accept;

  assign in_opcode = in_instruction[0 +: OPCODE_WIDTH];
  assign in_op_a   = in_instruction[OP_A_LSB +: REGISTER_ADDR_WIDTH];
  assign in_op_b   = in_instruction[OP_B_LSB +: REGISTER_ADDR_WIDTH];
  assign in_dest   = in_instruction[DEST_LSB +: REGISTER_ADDR_WIDTH];

  generate
    if (CHANNEL_ADDR_WIDTH > 0) begin : g_channel
      assign in_channel = in_instruction[CHANNEL_LSB +: CHANNEL_ADDR_WIDTH];
    end else begin : g_no_channel
      assign in_channel = '0;
    end
  endgenerate

  fcore_opcode_classifier #(
    .OPCODE_WIDTH (OPCODE_WIDTH)
  ) u_classifier (
    .opcode   (in_opcode),
    .op_class (in_class),
    .illegal  (in_illegal)
  );

  assign in_is_ldc  = (32'(in_opcode) == OP_LDC);
  assign in_is_stop = (32'(in_opcode) == OP_STOP);

  // Flush is a no-op while halted so a pending STOP on the output survives it.
  assign is_halted = (state_q == DEC_HALTED);
  assign flush_eff = flush && !is_halted;
  assign in_ready  = !is_halted && !flush && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d         = state_q;
    out_valid_d     = out_valid_q && !out_ready;
    out_opcode_d    = out_opcode_q;
    out_op_a_d      = out_op_a_q;
    out_op_b_d      = out_op_b_q;
    out_dest_d      = out_dest_q;
    out_channel_d   = out_channel_q;
    out_immediate_d = out_immediate_q;
    out_class_d     = out_class_q;
    out_illegal_d   = out_illegal_q;
    ldc_op_a_d      = ldc_op_a_q;
    ldc_op_b_d      = ldc_op_b_q;
    ldc_dest_d      = ldc_dest_q;
    ldc_channel_d   = ldc_channel_q;

    case (state_q)
      DEC_HALTED: begin
        if (start) begin
          state_d = DEC_RUN;
        end
      end
      DEC_RUN: begin
        if (accept && in_is_ldc) begin
          ldc_op_a_d    = in_op_a;
          ldc_op_b_d    = in_op_b;
          ldc_dest_d    = in_dest;
          ldc_channel_d = in_channel;
          state_d       = DEC_LDC_WAIT;
        end else if (accept) begin
          out_valid_d     = 1'b1;
          out_opcode_d    = in_opcode;
          out_op_a_d      = in_op_a;
          out_op_b_d      = in_op_b;
          out_dest_d      = in_dest;
          out_channel_d   = in_channel;
          out_immediate_d = '0;
          out_class_d     = in_class;
          out_illegal_d   = in_illegal;
          if (in_is_stop) begin
            state_d = DEC_HALTED;
          end
        end
      end
      DEC_LDC_WAIT: begin
        if (flush) begin
          ldc_op_a_d    = '0;
          ldc_op_b_d    = '0;
          ldc_dest_d    = '0;
          ldc_channel_d = '0;
          state_d       = DEC_RUN;
        end else if (accept) begin
          // The second word is raw constant data and is never decoded.
          out_valid_d     = 1'b1;
          out_opcode_d    = OPCODE_WIDTH'(OP_LDC);
          out_op_a_d      = ldc_op_a_q;
          out_op_b_d      = ldc_op_b_q;
          out_dest_d      = ldc_dest_q;
          out_channel_d   = ldc_channel_q;
          out_immediate_d = in_instruction;
          out_class_d     = CLASS_LOAD;
          out_illegal_d   = 1'b0;
          ldc_op_a_d      = '0;
          ldc_op_b_d      = '0;
          ldc_dest_d      = '0;
          ldc_channel_d   = '0;
          state_d         = DEC_RUN;
        end
      end
      default: begin
        state_d = DEC_HALTED;
      end
    endcase

    if (flush_eff) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= DEC_HALTED;
      out_valid_q     <= 1'b0;
      out_opcode_q    <= '0;
      out_op_a_q      <= '0;
      out_op_b_q      <= '0;
      out_dest_q      <= '0;
      out_channel_q   <= '0;
      out_immediate_q <= '0;
      out_class_q     <= '0;
      out_illegal_q   <= 1'b0;
      ldc_op_a_q      <= '0;
      ldc_op_b_q      <= '0;
      ldc_dest_q      <= '0;
      ldc_channel_q   <= '0;
    end else begin
      state_q         <= state_d;
      out_valid_q     <= out_valid_d;
      out_opcode_q    <= out_opcode_d;
      out_op_a_q      <= out_op_a_d;
      out_op_b_q      <= out_op_b_d;
      out_dest_q      <= out_dest_d;
      out_channel_q   <= out_channel_d;
      out_immediate_q <= out_immediate_d;
      out_class_q     <= out_class_d;
      out_illegal_q   <= out_illegal_d;
      ldc_op_a_q      <= ldc_op_a_d;
      ldc_op_b_q      <= ldc_op_b_d;
      ldc_dest_q      <= ldc_dest_d;
      ldc_channel_q   <= ldc_channel_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opcode    = out_opcode_q;
  assign out_op_a      = out_op_a_q;
  assign out_op_b      = out_op_b_q;
  assign out_dest      = out_dest_q;
  assign out_channel   = out_channel_q;
  assign out_immediate = out_immediate_q;
  assign out_class     = out_class_q;
  assign out_illegal   = out_illegal_q;
  assign halted        = is_halted;

endmodule
